// File: rtl/counter_pkg.sv
// Shared types and constants for the parametrised step counter family.
package counter_pkg;

    // Behaviour when a step would leave the range 0..MAX_VAL.
    typedef enum logic {
        CNT_WRAP,  // modulo (MAX_VAL+1) arithmetic
        CNT_SAT    // clip at 0 / MAX_VAL
    } cnt_mode_e;

    // Encoding of the dir input.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : counter_pkg

// File: rtl/cnt_next_calc.sv
// Combinational next-count calculator: applies one clamped step in the
// requested direction and reports whether the raw result left 0..MAX_VAL.
module cnt_next_calc
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] step,
    input  logic             dir,
    input  cnt_mode_e        mode,
    output logic [WIDTH-1:0] next,
    output logic             out_of_range
);

    // One extra bit so the raw up-sum and the wrap correction never overflow.
    localparam logic [WIDTH:0] MAX_X   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] MODULUS = (WIDTH+1)'(MAX_VAL + 1);

    logic [WIDTH:0] count_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] s_x;
    logic [WIDTH:0] sum;

    // Clamp the step, form the raw result and fold it back into range.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next         = count;
        out_of_range = 1'b0;
        count_x      = {1'b0, count};
        step_x       = {1'b0, step};
        s_x          = (step_x > MAX_X) ? MAX_X : step_x;
        sum          = count_x + s_x;

        if (dir == DIR_UP) begin
            out_of_range = (sum > MAX_X);
            if (!out_of_range)
                next = WIDTH'(sum);
            else if (mode == CNT_SAT)
                next = WIDTH'(MAX_X);
            else
                next = WIDTH'(sum - MODULUS);
        end else begin
            out_of_range = (s_x > count_x);
            if (!out_of_range)
                next = WIDTH'(count_x - s_x);
            else if (mode == CNT_SAT)
                next = '0;
            else
                next = WIDTH'(count_x + MODULUS - s_x);
        end
    end

endmodule : cnt_next_calc

// File: rtl/param_step_counter.sv
// Parametrised up/down step counter with wrap or saturate mode, programmable
// modulus, synchronous load, terminal-count pulse and sticky range flags.
module param_step_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VAL   = 2**WIDTH - 1,
    parameter cnt_mode_e   MODE      = CNT_WRAP,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    // Reject illegal parameter combinations at elaboration.
    if (WIDTH < 2) begin : g_bad_width
        $error("param_step_counter: WIDTH must be >= 2");
    end
    if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
        $error("param_step_counter: MAX_VAL must be in 1..2**WIDTH-1");
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_reset
        $error("param_step_counter: RESET_VAL must be <= MAX_VAL");
    end

    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             ovf_q;
    logic             unf_q;
    logic [WIDTH-1:0] next_count;
    logic             out_of_range;
    logic [WIDTH-1:0] load_clamped;
    logic             step_taken;
    logic             set_ovf;
    logic             set_unf;

    cnt_next_calc #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .count        (count_q),
        .step         (step),
        .dir          (dir),
        .mode         (MODE),
        .next         (next_count),
        .out_of_range (out_of_range)
    );

    // Load has priority over counting; an out-of-range load value saturates.
    assign load_clamped = (load_val > MAX_W) ? MAX_W : load_val;
    assign step_taken   = en && !load;
    assign set_ovf      = step_taken && out_of_range && (dir == DIR_UP);
    assign set_unf      = step_taken && out_of_range && (dir == DIR_DOWN);

    // Count register and terminal-count pulse: load > en > hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_W;
            tc_q    <= 1'b0;
        end else if (load) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            count_q <= load_clamped;
            tc_q    <= 1'b0;
        end else if (en) begin
            count_q <= next_count;
            tc_q    <= out_of_range;
        end else begin
            tc_q    <= 1'b0;
        end
    end

    // Sticky range flags; a same-cycle set beats clr_flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= set_ovf || (ovf_q && !clr_flags);
            unf_q <= set_unf || (unf_q && !clr_flags);
        end
    end

    assign count_out = count_q;
    assign tc        = tc_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule : param_step_counter

// File: tb/tb_param_step_counter.sv
// Directed bench for param_step_counter: three instances share the stimulus
// (MAX_VAL=15 wrap, MAX_VAL=9 wrap, MAX_VAL=15 saturate); each test checks
// the instance it targets against hand-computed values.
module tb_param_step_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       dir;
    logic [3:0] step;
    logic       load;
    logic [3:0] load_val;
    logic       clr_flags;

    logic [3:0] a_count, b_count, c_count;
    logic       a_tc, a_ovf, a_unf;
    logic       b_tc, b_ovf, b_unf;
    logic       c_tc, c_ovf, c_unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_step_counter #(.WIDTH(4), .MAX_VAL(15), .MODE(CNT_WRAP), .RESET_VAL(0)) u_a (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .step(step), .load(load),
        .load_val(load_val), .clr_flags(clr_flags),
        .count_out(a_count), .tc(a_tc), .ovf(a_ovf), .unf(a_unf));

    param_step_counter #(.WIDTH(4), .MAX_VAL(9), .MODE(CNT_WRAP), .RESET_VAL(0)) u_b (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .step(step), .load(load),
        .load_val(load_val), .clr_flags(clr_flags),
        .count_out(b_count), .tc(b_tc), .ovf(b_ovf), .unf(b_unf));

    param_step_counter #(.WIDTH(4), .MAX_VAL(15), .MODE(CNT_SAT), .RESET_VAL(0)) u_c (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .step(step), .load(load),
        .load_val(load_val), .clr_flags(clr_flags),
        .count_out(c_count), .tc(c_tc), .ovf(c_ovf), .unf(c_unf));

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges (we sit at edge+1, next edge is 9 units away).
    task automatic pulse_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; dir = DIR_UP; step = 4'd0;
        load = 1'b0; load_val = 4'd0; clr_flags = 1'b0;
        #2;
        check("rst_count", a_count, 0);
        check("rst_tc",    a_tc,    0);
        check("rst_ovf",   a_ovf,   0);
        check("rst_unf",   a_unf,   0);
        #10;
        reset = 1'b0;

        // Test 1: count up by 1 to 6, reset mid-count, then resume.
        en = 1'b1; dir = DIR_UP; step = 4'd1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("t1_up_%0d", i), a_count, i);
        end
        #2;
        reset = 1'b1;
        #1;
        check("t1_rst_count", a_count, 0);
        check("t1_rst_tc",    a_tc,    0);
        check("t1_rst_ovf",   a_ovf,   0);
        #2;
        reset = 1'b0;
        tick();
        check("t1_resume_1", a_count, 1);
        tick();
        check("t1_resume_2", a_count, 2);

        // Test 2: decade wrap, up step 3 then down step 4 (instance B, MAX_VAL=9).
        pulse_reset();
        step = 4'd3; dir = DIR_UP;
        tick(); check("t2_up_3", b_count, 3);
        tick(); check("t2_up_6", b_count, 6);
        tick(); check("t2_up_9", b_count, 9);
        check("t2_tc_at_9", b_tc, 0);
        tick(); check("t2_wrap_2", b_count, 2);
        check("t2_wrap_tc",  b_tc,  1);
        check("t2_wrap_ovf", b_ovf, 1);
        dir = DIR_DOWN; step = 4'd4;
        tick(); check("t2_down_8", b_count, 8);
        check("t2_down_tc",  b_tc,  1);
        check("t2_down_unf", b_unf, 1);

        // Test 3: saturate at 15, then exact fall to 0 (instance C).
        pulse_reset();
        en = 1'b0; load = 1'b1; load_val = 4'd13;
        tick(); check("t3_load_13", c_count, 13);
        load = 1'b0; en = 1'b1; dir = DIR_UP; step = 4'd2;
        tick(); check("t3_sat_a", c_count, 15); check("t3_sat_a_tc", c_tc, 0);
        tick(); check("t3_sat_b", c_count, 15); check("t3_sat_b_tc", c_tc, 1);
        tick(); check("t3_sat_c", c_count, 15); check("t3_sat_c_tc", c_tc, 1);
        check("t3_sat_ovf", c_ovf, 1);
        dir = DIR_DOWN; step = 4'd15;
        tick(); check("t3_down_0", c_count, 0);
        check("t3_down_tc",  c_tc,  0);
        check("t3_down_unf", c_unf, 0);

        // Test 4: load beats en and clamps; oversize step clamps (instance B).
        pulse_reset();
        load = 1'b1; en = 1'b1; dir = DIR_UP; step = 4'd1; load_val = 4'd12;
        tick(); check("t4_load_clamp", b_count, 9); check("t4_load_tc", b_tc, 0);
        pulse_reset();
        load = 1'b0; step = 4'd14;
        tick(); check("t4_step_clamp", b_count, 9); check("t4_step_tc", b_tc, 0);
        check("t4_step_ovf", b_ovf, 0);

        // Test 5: flag clear alone, and clear losing to a simultaneous set (instance B).
        pulse_reset();
        step = 4'd9; dir = DIR_UP;
        tick(); check("t5_up_9", b_count, 9);
        tick(); check("t5_wrap_8", b_count, 8); check("t5_ovf_set", b_ovf, 1);
        en = 1'b0; clr_flags = 1'b1;
        tick(); check("t5_ovf_clr", b_ovf, 0); check("t5_hold_8", b_count, 8);
        en = 1'b1;
        tick(); check("t5_wrap_7", b_count, 7); check("t5_wrap_tc", b_tc, 1);
        check("t5_set_wins", b_ovf, 1);
        clr_flags = 1'b0;

        // Test 6: hold with en=0 and with step=0; flags must not move (instance A).
        pulse_reset();
        en = 1'b0; load = 1'b1; load_val = 4'd7;
        tick(); check("t6_load_7", a_count, 7);
        load = 1'b0; en = 1'b1; dir = DIR_UP; step = 4'd15;
        tick(); check("t6_wrap_6", a_count, 6); check("t6_ovf", a_ovf, 1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t6_en0_count_%0d", i), a_count, 6);
            check($sformatf("t6_en0_tc_%0d", i),    a_tc,    0);
        end
        en = 1'b1; step = 4'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t6_s0_count_%0d", i), a_count, 6);
            check($sformatf("t6_s0_tc_%0d", i),    a_tc,    0);
        end
        check("t6_ovf_kept", a_ovf, 1);
        check("t6_unf_kept", a_unf, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_param_step_counter
